// File: rtl/butterfly_trace_capture.sv
// butterfly_trace_capture
//   On-chip trace of one selectable radix-2 butterfly stage. The selected
//   stage's operands {tw_im,tw_re,b_im,b_re,a_im,a_re} go through a
//   LATENCY-deep delay line so they line up with that stage's results.
//   Each oact of the traced stage pushes a {results, operands} record into a
//   DEPTH-entry first-word-fall-through FIFO, which is read over rd_valid/rd_ready.
//
//   Optional feature macro: BFLY_TRACE_ALIGN_CHECK_EN
//     When defined, the delay line carries a valid tag per entry. An oact that
//     meets an empty tap sets align_err, which stays set until arm or reset.
//     When undefined, there is no tag storage and align_err is tied to 0.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   arm             pulse: sample stage_sel, flush FIFO/flags, start capture
//   stage_sel       stage to trace (sampled only on arm)
//   iact / oact     per-stage input / output valid strobes
//   in_ops          per-stage operands, stage 0 in LSBs (6*DATA_W each)
//   out_res         per-stage results {ob_im,ob_re,oa_im,oa_re} (4*DATA_W each)
//   rd_ready        consumer accepts rd_data
//   rd_valid        FIFO non-empty
//   rd_data         head record {results, operands}; 0 when empty
//   level           records held
//   busy            ARMED or CAPTURE
//   done            DEPTH records captured since arm
//   align_err       sticky operand/result misalignment flag
module butterfly_trace_capture #(
  parameter int DATA_W     = 16,
  parameter int NUM_STAGES = 10,
  parameter int LATENCY    = 6,
  parameter int DEPTH      = 64,
  localparam int STAGE_W   = $clog2(NUM_STAGES),
  localparam int REC_W     = 10*DATA_W,
  localparam int LVL_W     = $clog2(DEPTH)+1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic [STAGE_W-1:0]             stage_sel,
  input  logic [NUM_STAGES-1:0]          iact,
  input  logic [NUM_STAGES-1:0]          oact,
  input  logic [NUM_STAGES*6*DATA_W-1:0] in_ops,
  input  logic [NUM_STAGES*4*DATA_W-1:0] out_res,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [REC_W-1:0]               rd_data,
  output logic [LVL_W-1:0]               level,
  output logic                           busy,
  output logic                           done,
  output logic                           align_err
);

  localparam int OPS_W = 6*DATA_W;
  localparam int RES_W = 4*DATA_W;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                  state, state_n;
  logic [STAGE_W-1:0]      sel_q;
  logic                    sel_iact, sel_oact;
  logic [OPS_W-1:0]        sel_ops;
  logic [RES_W-1:0]        sel_res;
  logic [LATENCY-1:0][OPS_W-1:0] dl_ops;
  logic [LVL_W-1:0]        wr_cnt;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [REC_W-1:0]        mem [DEPTH];
  logic                    push, pop;

  // Stage mux. An out-of-range selection matches no stage and so sees no strobes.
  always_comb begin
    sel_iact = 1'b0;
    sel_oact = 1'b0;
    sel_ops  = '0;
    sel_res  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (sel_q == STAGE_W'(i)) begin
        sel_iact = iact[i];
        sel_oact = oact[i];
        sel_ops  = in_ops[i*OPS_W +: OPS_W];
        sel_res  = out_res[i*RES_W +: RES_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sel_q <= '0;
    else if (arm) sel_q <= stage_sel;
  end

  // Operand delay line: dl_ops[LATENCY-1] holds the operands that arrived
  // exactly LATENCY cycles before the current cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_ops <= '0;
    end else begin
      dl_ops[0] <= sel_ops;
      for (int i = 1; i < LATENCY; i++) dl_ops[i] <= dl_ops[i-1];
    end
  end

`ifdef BFLY_TRACE_ALIGN_CHECK_EN
  logic [LATENCY-1:0] vld_pipe;
  logic               align_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (arm) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= sel_iact;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // The record is written regardless; the flag only reports it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                align_err_q <= 1'b0;
    else if (arm)                             align_err_q <= 1'b0;
    else if (push && !vld_pipe[LATENCY-1])    align_err_q <= 1'b1;
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  // Arm overrides any push/pop of the same cycle: the FIFO is being flushed.
  assign push = (state == S_CAPTURE) && sel_oact && !arm;
  assign pop  = rd_valid && rd_ready && !arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = S_IDLE;
      S_ARMED:   if (sel_iact) state_n = S_CAPTURE;
      S_CAPTURE: if (push && wr_cnt == LVL_W'(DEPTH-1)) state_n = S_DONE;
      S_DONE:    state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
    if (arm) state_n = S_ARMED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     wr_cnt <= '0;
    else if (arm)  wr_cnt <= '0;
    else if (push) wr_cnt <= wr_cnt + 1'b1;
  end

  // Record storage is not reset; rd_data is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_res, dl_ops[LATENCY-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_valid = (level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign busy     = (state == S_ARMED) || (state == S_CAPTURE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_butterfly_trace_capture.sv
// Bench for butterfly_trace_capture: directed vectors, a vector table pushed
// through the alignment path, and hand-written multi-cycle corner sequences.
module tb_butterfly_trace_capture;
  localparam int DW = 16, NS = 10, LAT = 6, DEP = 64;

  logic              clk = 1'b0;
  logic              reset, arm, rd_ready;
  logic [3:0]        stage_sel;
  logic [NS-1:0]     iact, oact;
  logic [NS*6*DW-1:0] in_ops;
  logic [NS*4*DW-1:0] out_res;
  logic              rd_valid, busy, done, align_err;
  logic [10*DW-1:0]  rd_data;
  logic [6:0]        level;

  int errs = 0, checks = 0;

  butterfly_trace_capture #(.DATA_W(DW), .NUM_STAGES(NS), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stage_sel(stage_sel), .iact(iact), .oact(oact),
    .in_ops(in_ops), .out_res(out_res), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .level(level), .busy(busy), .done(done), .align_err(align_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] ops;
    logic [63:0] res;
    logic [15:0] exp_a_re;
    logic [15:0] exp_oa_re;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic i, input logic [95:0] op,
                       input logic o, input logic [63:0] rs);
    iact = '0;
    oact = '0;
    iact[s] = i;
    oact[s] = o;
    in_ops[s*96 +: 96] = op;
    out_res[s*64 +: 64] = rs;
  endtask

  task automatic do_arm(input int s);
    arm = 1'b1;
    stage_sel = 4'(s);
    iact = '0;
    oact = '0;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [95:0] mk_ops(input int k);
    return {16'(k ^ 'h5A5A), 16'(k + 3), 16'(k * 2), 16'(k + 1), 16'(~k), 16'(k)};
  endfunction

  function automatic logic [63:0] mk_res(input int k);
    return {16'(k + 400), 16'(k + 300), 16'(k + 200), 16'(k + 100)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_align;
    tbl[0] = '{ops: {16'h0006, 16'h7FFF, 16'hFFFE, 16'h0002, 16'h8000, 16'h0001},
               res: {16'h1111, 16'h2222, 16'h3333, 16'h4444}, exp_a_re: 16'h0001, exp_oa_re: 16'h4444};
    tbl[1] = '{ops: {16'hA5A5, 16'h0000, 16'h7FFF, 16'h8001, 16'h0000, 16'hFFFF},
               res: {16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF}, exp_a_re: 16'hFFFF, exp_oa_re: 16'hFFFF};
    tbl[2] = '{ops: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1357, 16'h2468},
               res: {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, exp_a_re: 16'h2468, exp_oa_re: 16'hF00D};
    tbl[3] = '{ops: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
               res: {16'h0001, 16'h0002, 16'h0003, 16'h0004}, exp_a_re: 16'h0000, exp_oa_re: 16'h0004};

    reset = 1'b1; arm = 1'b0; rd_ready = 1'b0; stage_sel = '0;
    iact = '0; oact = '0;
    in_ops = {60{16'hDEAD}};
    out_res = {40{16'hBEEF}};
    tick(); tick();

    // Reset values
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_align_err", align_err, 0);
    reset = 1'b0;
    tick();

    // Single record on stage 3, non-selected oacts ignored
    do_arm(3);
    chk("armed_busy", busy, 1);
    tick(); tick();
    drive(3, 1'b1, {16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 16'hFF00, 16'h0100}, 1'b0, '0);
    drive(2, 1'b1, {6{16'h3333}}, 1'b0, '0);   // other stage's data must not leak in
    iact = 10'b00_0000_1000;
    tick();                                     // iact[3] sampled (cycle 10)
    for (int c = 11; c <= 15; c++) begin
      drive(3, 1'b0, {6{16'h5555}}, 1'b0, '0);
      oact = (c % 2 == 1) ? 10'b00_0000_0100 : 10'b00_0001_0000;
      tick();
    end
    chk("other_oact_level", level, 0);
    drive(3, 1'b0, {6{16'h5555}}, 1'b1, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    chk("pre_push_rd_valid", rd_valid, 0);
    tick();                                     // oact[3] sampled (cycle 16)
    oact = '0;
    chk("push_rd_valid", rd_valid, 1);
    chk("push_a_re", rd_data[15:0], 16'h0100);
    chk("push_tw_re", rd_data[79:64], 16'h7FFF);
    chk("push_record", rd_data,
        {16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 16'hFF00, 16'h0100});
    tick();
    chk("hold_rd_data_a_im", rd_data[31:16], 16'hFF00);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pop_level", level, 0);
    chk("empty_rd_data", rd_data, 0);

    // Vector table through the delay line on stage 5
    do_arm(5);
    for (int k = 0; k < 10; k++) begin
      drive(5, k < 4, (k < 4) ? tbl[k].ops : 96'h0, k >= 6, (k >= 6) ? tbl[k-6].res : 64'h0);
      tick();
    end
    iact = '0; oact = '0;
    chk("tbl_level", level, 4);
    chk("tbl_align_err", align_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl%0d_a_re", i), rd_data[15:0], tbl[i].exp_a_re);
      chk($sformatf("tbl%0d_oa_re", i), rd_data[111:96], tbl[i].exp_oa_re);
      chk($sformatf("tbl%0d_record", i), rd_data, {tbl[i].res, tbl[i].ops});
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    chk("tbl_drained", level, 0);

    // Fill to DEPTH with rd_ready low, then drain in order
    do_arm(7);
    for (int k = 0; k < 70; k++) begin
      drive(7, k < 64, mk_ops(k), k >= 6, mk_res(k - 6));
      tick();
    end
    iact = '0; oact = '0;
    chk("full_level", level, 64);
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    drive(7, 1'b1, mk_ops(99), 1'b1, mk_res(99));
    tick();
    iact = '0; oact = '0;
    chk("extra_oact_level", level, 64);
    rd_ready = 1'b1;
    for (int j = 0; j < 64; j++) begin
      if (rd_data !== {mk_res(j), mk_ops(j)}) chk($sformatf("drain%0d", j), rd_data, {mk_res(j), mk_ops(j)});
      else checks++;
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_rd_valid", rd_valid, 0);
    chk("drain_done_persists", done, 1);

    // Steady push and pop every cycle
    do_arm(1);
    rd_ready = 1'b1;
    for (int k = 0; k < 26; k++) begin
      drive(1, k < 20, mk_ops(k + 500), k >= 6, mk_res(k + 494));
      tick();
      if (k >= 6) begin
        chk($sformatf("steady%0d_level", k), level, 1);
        chk($sformatf("steady%0d_rec", k), rd_data, {mk_res(k + 494), mk_ops(k + 494)});
      end
    end
    iact = '0; oact = '0;
    tick();
    rd_ready = 1'b0;
    chk("steady_final_level", level, 0);
    chk("steady_not_done", done, 0);

    // oact with no matching iact LATENCY cycles earlier
    do_arm(2);
    drive(2, 1'b1, mk_ops(7), 1'b0, '0);
    tick();
    drive(2, 1'b0, mk_ops(8), 1'b0, '0);
    tick(); tick();
    drive(2, 1'b0, mk_ops(9), 1'b1, mk_res(9));
    tick();
    oact = '0;
`ifdef BFLY_TRACE_ALIGN_CHECK_EN
    exp_align = 1'b1;
`else
    exp_align = 1'b0;
`endif
    chk("align_level", level, 1);
    chk("align_err", align_err, exp_align);
    tick();
    chk("align_err_sticky", align_err, exp_align);
    do_arm(2);
    chk("rearm_align_err", align_err, 0);
    chk("rearm_level", level, 0);

    // Reset mid-capture with 5 records held
    do_arm(0);
    for (int k = 0; k < 11; k++) begin
      drive(0, k < 8, mk_ops(k), k >= 6 && k < 11, mk_res(k));
      tick();
    end
    iact = '0; oact = '0;
    chk("pre_reset_level", level, 5);
    reset = 1'b1;
    tick();
    chk("midrst_level", level, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
